// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path: data/address
// widths, the x0 constant, the queued write request and the requester id.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // One pending register-file write as it sits in a requester FIFO.
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // Identifies a writeback requester.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus bundle: two requester handshakes, the registered register
// file write port, the decode hazard query and the idle flag.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic              p0_valid;
  logic              p0_ready;
  logic [REG_AW-1:0] p0_addr;
  logic [XLEN-1:0]   p0_data;

  logic              p1_valid;
  logic              p1_ready;
  logic [REG_AW-1:0] p1_addr;
  logic [XLEN-1:0]   p1_data;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  logic [REG_AW-1:0] hz_addr;
  logic              hz_busy;
  logic              idle;

  // The side that issues writes and queries hazards.
  modport master (
    output p0_valid, p0_addr, p0_data,
    output p1_valid, p1_addr, p1_data,
    output hz_addr,
    input  p0_ready, p1_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  hz_busy, idle
  );

  // The arbiter itself.
  modport slave (
    input  p0_valid, p0_addr, p0_data,
    input  p1_valid, p1_addr, p1_data,
    input  hz_addr,
    output p0_ready, p1_ready,
    output rf_we, rf_waddr, rf_wdata,
    output hz_busy, idle
  );

endinterface

// File: rtl/regfile_wb_fifo.sv
// Per-requester writeback FIFO. Holds DEPTH write requests (DEPTH a power
// of two, >= 2) and exposes every slot's occupancy and address so the top
// can answer hazard queries against everything still queued.
module regfile_wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  wb_req_t                      entry_i,
  input  logic                         pop_i,
  output logic                         full_o,
  output logic                         empty_o,
  output wb_req_t                      head_o,
  output logic [DEPTH-1:0]             slot_valid_o,
  output logic [DEPTH-1:0][REG_AW-1:0] slot_addr_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;
  logic [PW-1:0] offset;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage array; contents are don't-care once the pointers are flushed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    slot_valid_o = '0;
    slot_addr_o  = '0;
    offset       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset          = PW'(i) - rd_ptr_q;
      slot_valid_o[i] = ({1'b0, offset} < count_q);
      slot_addr_o[i]  = mem_q[i].addr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port. Two
// requester FIFOs feed a registered write bus; x0 writes are consumed but
// never issued. Arbitration is fixed priority (port 0 wins) unless
// REGFILE_WB_RR_ARB_EN is defined, which switches to round-robin.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave bus
);

  wb_req_t                      head0, head1, entry0, entry1, sel;
  logic                         full0, full1, empty0, empty1;
  logic                         push0, push1, grant0, grant1;
  logic [DEPTH-1:0]             sv0, sv1;
  logic [DEPTH-1:0][REG_AW-1:0] sa0, sa1;
  logic                         hit;

  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

`ifdef REGFILE_WB_RR_ARB_EN
  port_e last_grant_q;
`endif

  assign bus.p0_ready = !rst && !full0;
  assign bus.p1_ready = !rst && !full1;
  assign push0  = bus.p0_valid && bus.p0_ready;
  assign push1  = bus.p1_valid && bus.p1_ready;
  assign entry0 = '{addr: bus.p0_addr, data: bus.p0_data};
  assign entry1 = '{addr: bus.p1_addr, data: bus.p1_data};

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push0),
    .entry_i      (entry0),
    .pop_i        (grant0),
    .full_o       (full0),
    .empty_o      (empty0),
    .head_o       (head0),
    .slot_valid_o (sv0),
    .slot_addr_o  (sa0)
  );

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push1),
    .entry_i      (entry1),
    .pop_i        (grant1),
    .full_o       (full1),
    .empty_o      (empty1),
    .head_o       (head1),
    .slot_valid_o (sv1),
    .slot_addr_o  (sa1)
  );

  // Pick at most one non-empty FIFO head per cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef REGFILE_WB_RR_ARB_EN
    if (!empty0 && !empty1) begin
      if (last_grant_q == PORT1) grant0 = 1'b1;
      else                       grant1 = 1'b1;
    end else begin
      grant0 = !empty0;
      grant1 = !empty1;
    end
`else
    grant0 = !empty0;
    grant1 = empty0 && !empty1;
`endif
  end

  // Next write-bus value: granted head, with x0 suppressed to we=0.
  always_comb begin
    sel        = grant1 ? head1 : head0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant0 || grant1) begin
      rf_we_d    = (sel.addr != REG_ZERO);
      rf_waddr_d = sel.addr;
      rf_wdata_d = sel.data;
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

`ifdef REGFILE_WB_RR_ARB_EN
  // Remember who won last, x0 grants included, so contention alternates.
  always_ff @(posedge clk) begin
    if (rst)         last_grant_q <= PORT1;
    else if (grant0) last_grant_q <= PORT0;
    else if (grant1) last_grant_q <= PORT1;
  end
`endif

  // Hazard match against every queued slot and the write in flight.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sv0[i] && (sa0[i] == bus.hz_addr)) hit = 1'b1;
      if (sv1[i] && (sa1[i] == bus.hz_addr)) hit = 1'b1;
    end
    if (rf_we_q && (rf_waddr_q == bus.hz_addr)) hit = 1'b1;
  end

  assign bus.hz_busy  = !rst && (bus.hz_addr != REG_ZERO) && hit;
  assign bus.idle     = rst || (empty0 && empty1 && !rf_we_q);
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model. Honours
// REGFILE_WB_RR_ARB_EN to select the expected arbitration policy.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: one queue per port plus the write-bus register.
  wb_req_t     q0[$];
  wb_req_t     q1[$];
  logic        mWe = 1'b0;
  logic [4:0]  mWaddr = '0;
  logic [31:0] mWdata = '0;
`ifdef REGFILE_WB_RR_ARB_EN
  int          mLast = 1;
`endif

  // Hard stop in case the run ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic modelStep();
    logic    rdy0, rdy1;
    int      g;
    wb_req_t h;
    if (rst) begin
      q0.delete();
      q1.delete();
      mWe = 1'b0;
      mWaddr = '0;
      mWdata = '0;
`ifdef REGFILE_WB_RR_ARB_EN
      mLast = 1;
`endif
      return;
    end
    rdy0 = (q0.size() != DEPTH);
    rdy1 = (q1.size() != DEPTH);
    g = -1;
    if (q0.size() > 0 && q1.size() > 0) begin
`ifdef REGFILE_WB_RR_ARB_EN
      g = (mLast == 1) ? 0 : 1;
`else
      g = 0;
`endif
    end else if (q0.size() > 0) g = 0;
    else if (q1.size() > 0) g = 1;
    if (g >= 0) begin
      if (g == 0) h = q0.pop_front();
      else        h = q1.pop_front();
      mWe = (h.addr != 5'd0);
      mWaddr = h.addr;
      mWdata = h.data;
`ifdef REGFILE_WB_RR_ARB_EN
      mLast = g;
`endif
    end else begin
      mWe = 1'b0;
    end
    if (bus.p0_valid && rdy0) q0.push_back('{addr: bus.p0_addr, data: bus.p0_data});
    if (bus.p1_valid && rdy1) q1.push_back('{addr: bus.p1_addr, data: bus.p1_data});
  endtask

  function automatic logic modelHz(input logic [4:0] a);
    if (rst || a == 5'd0) return 1'b0;
    foreach (q0[i]) if (q0[i].addr == a) return 1'b1;
    foreach (q1[i]) if (q1[i].addr == a) return 1'b1;
    return mWe && (mWaddr == a);
  endfunction

  task automatic checkOutput();
    checkEq("rf_we", 32'(bus.rf_we), 32'(mWe));
    if (mWe) begin
      checkEq("rf_waddr", 32'(bus.rf_waddr), 32'(mWaddr));
      checkEq("rf_wdata", bus.rf_wdata, mWdata);
    end
    checkEq("p0_ready", 32'(bus.p0_ready), 32'(!rst && q0.size() != DEPTH));
    checkEq("p1_ready", 32'(bus.p1_ready), 32'(!rst && q1.size() != DEPTH));
    checkEq("idle", 32'(bus.idle), 32'(rst || (q0.size() == 0 && q1.size() == 0 && !mWe)));
    checkEq("hz_busy", 32'(bus.hz_busy), 32'(modelHz(bus.hz_addr)));
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.p0_valid = v0;
    bus.p0_addr  = a0;
    bus.p0_data  = d0;
    bus.p1_valid = v1;
    bus.p1_addr  = a1;
    bus.p1_data  = d1;
    tick();
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.hz_addr = 5'd0;
    bus.p0_valid = 1'b0; bus.p0_addr = '0; bus.p0_data = '0;
    bus.p1_valid = 1'b0; bus.p1_addr = '0; bus.p1_data = '0;

    // Reset state while rst is held.
    rst = 1'b1;
    applyStimulus(1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
    checkEq("rst_p0_ready", 32'(bus.p0_ready), 0);
    checkEq("rst_idle", 32'(bus.idle), 1);
    checkEq("rst_rf_we", 32'(bus.rf_we), 0);
    rst = 1'b0;

    // Single write: visible exactly one cycle, two edges after the push.
    applyStimulus(1, 5'd5, 32'h0000_1234, 0, 0, 0);
    checkEq("single_we_e1", 32'(bus.rf_we), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkEq("single_we_e2", 32'(bus.rf_we), 1);
    checkEq("single_waddr", 32'(bus.rf_waddr), 5);
    checkEq("single_wdata", bus.rf_wdata, 32'h0000_1234);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkEq("single_we_e3", 32'(bus.rf_we), 0);
    checkEq("single_idle", 32'(bus.idle), 1);

    // Simultaneous pushes after reset: port 0 first in either policy.
    doReset();
    applyStimulus(1, 5'd1, 32'hA, 1, 5'd2, 32'hB);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkEq("simul_first_addr", 32'(bus.rf_waddr), 1);
    checkEq("simul_first_data", bus.rf_wdata, 32'hA);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkEq("simul_second_addr", 32'(bus.rf_waddr), 2);
    checkEq("simul_second_data", bus.rf_wdata, 32'hB);
    idleCycles(2);

    // Contention: both ports kept busy; the model tracks grant order.
    doReset();
    for (int i = 0; i < 24; i++)
      applyStimulus(1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom);
    idleCycles(8);

    // Starvation: port 0 saturated, port 1 pushing too.
    doReset();
    for (int i = 0; i < 12; i++)
      applyStimulus(1, 5'd9, 32'(i), 1, 5'd10, 32'(100 + i));
`ifndef REGFILE_WB_RR_ARB_EN
    checkEq("starve_p1_ready", 32'(bus.p1_ready), 0);
`endif
    idleCycles(8);
    checkEq("starve_drained_idle", 32'(bus.idle), 1);

    // x0 discard.
    doReset();
    bus.hz_addr = 5'd0;
    applyStimulus(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);
    checkEq("x0_hz", 32'(bus.hz_busy), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkEq("x0_we", 32'(bus.rf_we), 0);
    checkEq("x0_idle", 32'(bus.idle), 1);
    idleCycles(2);

    // Hazard window for x7 queued on port 1.
    doReset();
    bus.hz_addr = 5'd7;
    applyStimulus(0, 0, 0, 1, 5'd7, 32'h77);
    checkEq("hz_queued", 32'(bus.hz_busy), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkEq("hz_inflight", 32'(bus.hz_busy), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkEq("hz_cleared", 32'(bus.hz_busy), 0);

    // Mid-operation reset with three writes outstanding.
    doReset();
    applyStimulus(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
    applyStimulus(1, 5'd6, 32'h66, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    checkEq("midrst_we", 32'(bus.rf_we), 0);
    checkEq("midrst_idle", 32'(bus.idle), 1);
    checkEq("midrst_p0_ready", 32'(bus.p0_ready), 1);
    checkEq("midrst_p1_ready", 32'(bus.p1_ready), 1);
    idleCycles(4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus.hz_addr = 5'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end
    rst = 1'b0;
    idleCycles(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
